// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the playfield game-flow logic.
//   game_state_e   : sequencer states. The encoding is also shown on the HUD.
//   PAL_L0..PAL_L2 : palette indices used for levels 0..2.
//   level_palette  : maps a level index to its 4-bit palette index.
//                    Unknown levels fall back to the level-0 colour.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HIT   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } game_state_e;

    localparam logic [3:0] PAL_L0 = 4'd3;
    localparam logic [3:0] PAL_L1 = 4'd6;
    localparam logic [3:0] PAL_L2 = 4'd10;

    function automatic logic [3:0] level_palette(input logic [1:0] level);
        logic [3:0] pal;
        case (level)
            2'd0:    pal = PAL_L0;
            2'd1:    pal = PAL_L1;
            2'd2:    pal = PAL_L2;
            default: pal = PAL_L0;
        endcase
        return pal;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Counts frame ticks for the HIT and CLEAR freeze periods. One instance serves
// both states.
//   Clk          : system clock
//   Reset        : synchronous, active-high; clears the count
//   clear_i      : restart the count at zero; has priority over frame_tick_i
//   frame_tick_i : count enable, one pulse per frame
//   last_i       : terminal count, equal to (frames to wait - 1)
//   done_o       : high on the tick that completes the wait period
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear_i,
    input  logic             frame_tick_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // done fires on the tick itself. The sequencer therefore leaves the
    // state on the Nth tick after entry.
    assign done_o = frame_tick_i && (count_q == last_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (frame_tick_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/level_controller.sv
// -----------------------------------------------------------------------------
// level_controller
// Game-flow sequencer. It tracks lives and level progression using the
// per-frame hit flags from the color mapper. It also drives the palette, the
// obstacle speed and the respawn/freeze controls of the motion logic.
//   Clk, Reset          : clock and synchronous active-high reset
//   frame_tick          : one-cycle pulse per video frame
//   start               : start key; only its rising edge is used
//   collision           : player/obstacle overlap
//   finish_line_reached : player at the finish column
//   current_level       : active level index
//   foreground/background: palette indices for the current level
//   obs_speed           : obstacle step per frame
//   reset_player        : one-cycle pulse on every entry into PLAY
//   freeze              : motion logic holds positions when high
//   lives               : remaining lives
//   game_state          : encoded state for the HUD
// -----------------------------------------------------------------------------
module level_controller
    import game_pkg::*;
#(
    parameter int NUM_LEVELS     = 3,
    parameter int LIVES_INIT     = 3,
    parameter int HIT_FRAMES     = 60,
    parameter int CLEAR_FRAMES   = 90,
    parameter int OBS_SPEED_BASE = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       collision,
    input  logic       finish_line_reached,
    output logic [1:0] current_level,
    output logic [3:0] foreground,
    output logic [3:0] background,
    output logic [3:0] obs_speed,
    output logic       reset_player,
    output logic       freeze,
    output logic [1:0] lives,
    output logic [2:0] game_state
);

    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);
    localparam logic [1:0]       LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);

    game_state_e      state_q, state_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       lives_q, lives_d;
    logic             start_q;
    logic             reset_player_q, reset_player_d;
    logic             start_edge;
    logic             timer_clear;
    logic             timer_tick;
    logic             timer_done;
    logic [CNT_W-1:0] timer_last;

    // start_q resets high. A key held through reset then gives no edge.
    assign start_edge = start & ~start_q;

    // The timer only runs while frozen in HIT or CLEAR. It compares against
    // the terminal count for whichever of the two states is active.
    assign timer_tick = frame_tick && ((state_q == ST_HIT) || (state_q == ST_CLEAR));
    assign timer_last = (state_q == ST_HIT) ? HIT_LAST : CLEAR_LAST;

    frame_timer #(
        .CNT_W(CNT_W)
    ) u_frame_timer (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear_i     (timer_clear),
        .frame_tick_i(timer_tick),
        .last_i      (timer_last),
        .done_o      (timer_done)
    );

    // Next-state logic. reset_player_d is raised on every path into PLAY,
    // so the registered pulse lines up with the new state. In PLAY, finish
    // is checked before collision so that finishing wins a tie.
    always_comb begin
        state_d        = state_q;
        level_d        = level_q;
        lives_d        = lives_q;
        reset_player_d = 1'b0;
        timer_clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_edge) begin
                    state_d        = ST_PLAY;
                    level_d        = 2'd0;
                    lives_d        = LIVES_RST;
                    reset_player_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (finish_line_reached) begin
                        state_d     = ST_CLEAR;
                        timer_clear = 1'b1;
                    end else if (collision) begin
                        if (lives_q > 2'd1) begin
                            lives_d     = lives_q - 2'd1;
                            state_d     = ST_HIT;
                            timer_clear = 1'b1;
                        end else begin
                            lives_d = 2'd0;
                            state_d = ST_OVER;
                        end
                    end
                end
            end
            ST_HIT: begin
                if (timer_done) begin
                    state_d        = ST_PLAY;
                    reset_player_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (timer_done) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d        = level_q + 2'd1;
                        state_d        = ST_PLAY;
                        reset_player_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holds the sequencer registers. Reset drops any pending pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            level_q        <= 2'd0;
            lives_q        <= LIVES_RST;
            start_q        <= 1'b1;
            reset_player_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            lives_q        <= lives_d;
            start_q        <= start;
            reset_player_q <= reset_player_d;
        end
    end

    assign current_level = level_q;
    assign foreground    = level_palette(level_q);
    assign background    = level_palette(level_q);
    assign obs_speed     = 4'(OBS_SPEED_BASE) + {2'b00, level_q};
    assign reset_player  = reset_player_q;
    assign freeze        = (state_q != ST_PLAY);
    assign lives         = lives_q;
    assign game_state    = state_q;

endmodule

// File: tb/tb_level_controller.sv
// -----------------------------------------------------------------------------
// tb_level_controller
// Self-checking bench for level_controller. It applies a table of start-up
// vectors, then hand-written game sequences, then random play. Every cycle
// the outputs are compared against a rule-level model of the game.
// -----------------------------------------------------------------------------
module tb_level_controller;

    localparam int NUM_LEVELS   = 3;
    localparam int LIVES_INIT   = 3;
    localparam int HIT_FRAMES   = 60;
    localparam int CLEAR_FRAMES = 90;
    localparam int SPEED_BASE   = 1;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_HIT   = 2;
    localparam int S_CLEAR = 3;
    localparam int S_OVER  = 4;
    localparam int S_WIN   = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b1;
    logic       collision = 1'b0;
    logic       finish_line_reached = 1'b0;
    logic [1:0] current_level;
    logic [3:0] foreground;
    logic [3:0] background;
    logic [3:0] obs_speed;
    logic       reset_player;
    logic       freeze;
    logic [1:0] lives;
    logic [2:0] game_state;

    int total = 0;
    int bad   = 0;

    // Model state for the game. The frozen-period progress is tracked as
    // the number of ticks seen since entering HIT/CLEAR.
    int mState     = S_IDLE;
    int mLevel     = 0;
    int mLives     = LIVES_INIT;
    int mTicks     = 0;
    bit mStartPrev = 1'b1;
    bit mPulse     = 1'b0;

    typedef struct {
        bit rst;
        bit tick;
        bit st;
        bit coll;
        bit fin;
        int expState;
        int expLives;
        int expLevel;
        bit expPulse;
    } vec_t;

    vec_t vecs[$];

    level_controller #(
        .NUM_LEVELS    (NUM_LEVELS),
        .LIVES_INIT    (LIVES_INIT),
        .HIT_FRAMES    (HIT_FRAMES),
        .CLEAR_FRAMES  (CLEAR_FRAMES),
        .OBS_SPEED_BASE(SPEED_BASE)
    ) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .frame_tick         (frame_tick),
        .start              (start),
        .collision          (collision),
        .finish_line_reached(finish_line_reached),
        .current_level      (current_level),
        .foreground         (foreground),
        .background         (background),
        .obs_speed          (obs_speed),
        .reset_player       (reset_player),
        .freeze             (freeze),
        .lives              (lives),
        .game_state         (game_state)
    );

    always #5 Clk = ~Clk;

    function automatic int pal(input int lvl);
        if (lvl == 1) return 6;
        if (lvl == 2) return 10;
        return 3;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model by one clock, using the game rules directly.
    task automatic modelStep(input bit r, input bit t, input bit s, input bit c, input bit f);
        bit startEdge;
        bit enterPlay;
        startEdge = s && !mStartPrev;
        enterPlay = 1'b0;
        if (r) begin
            mState = S_IDLE;
            mLevel = 0;
            mLives = LIVES_INIT;
            mTicks = 0;
            mStartPrev = 1'b1;
            mPulse = 1'b0;
            return;
        end
        if (mState == S_IDLE || mState == S_OVER || mState == S_WIN) begin
            if (startEdge) begin
                mState = S_PLAY; mLevel = 0; mLives = LIVES_INIT; enterPlay = 1'b1;
            end
        end else if (mState == S_PLAY) begin
            if (t && f) begin
                mState = S_CLEAR; mTicks = 0;
            end else if (t && c) begin
                if (mLives > 1) begin
                    mLives--; mState = S_HIT; mTicks = 0;
                end else begin
                    mLives = 0; mState = S_OVER;
                end
            end
        end else if (t) begin
            mTicks++;
            if (mState == S_HIT && mTicks == HIT_FRAMES) begin
                mState = S_PLAY; enterPlay = 1'b1;
            end else if (mState == S_CLEAR && mTicks == CLEAR_FRAMES) begin
                if (mLevel == NUM_LEVELS - 1) begin
                    mState = S_WIN;
                end else begin
                    mLevel++; mState = S_PLAY; enterPlay = 1'b1;
                end
            end
        end
        mPulse = enterPlay;
        mStartPrev = s;
    endtask

    task automatic checkOutput();
        cmp("game_state", int'(game_state), mState);
        cmp("lives", int'(lives), mLives);
        cmp("current_level", int'(current_level), mLevel);
        cmp("foreground", int'(foreground), pal(mLevel));
        cmp("background", int'(background), pal(mLevel));
        cmp("obs_speed", int'(obs_speed), SPEED_BASE + mLevel);
        cmp("reset_player", int'(reset_player), int'(mPulse));
        cmp("freeze", int'(freeze), int'(mState != S_PLAY));
    endtask

    // Drives one cycle of inputs at the falling edge and steps the model.
    // The DUT is then sampled at the next falling edge.
    task automatic applyStimulus(input bit r, input bit t, input bit s, input bit c, input bit f);
        Reset = r;
        frame_tick = t;
        start = s;
        collision = c;
        finish_line_reached = f;
        modelStep(r, t, s, c, f);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput();
    endtask

    task automatic runTicks(input int n, input bit c, input bit f);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, c, f);
    endtask

    initial begin
        vecs.push_back('{1, 0, 1, 0, 0, S_IDLE, 3, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 0, S_IDLE, 3, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, S_IDLE, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, S_IDLE, 3, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, S_PLAY, 3, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 0, S_PLAY, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, S_PLAY, 3, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 1, S_PLAY, 3, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, S_HIT,  2, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, S_HIT,  2, 0, 0});

        @(negedge Clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].st, vecs[i].coll, vecs[i].fin);
            cmp($sformatf("vec%0d_state", i), int'(game_state), vecs[i].expState);
            cmp($sformatf("vec%0d_lives", i), int'(lives), vecs[i].expLives);
            cmp($sformatf("vec%0d_level", i), int'(current_level), vecs[i].expLevel);
            cmp($sformatf("vec%0d_pulse", i), int'(reset_player), int'(vecs[i].expPulse));
        end

        // Collision held throughout HIT; lives must not drop further.
        runTicks(HIT_FRAMES - 1, 1'b1, 1'b0);
        cmp("hit_hold_state", int'(game_state), S_HIT);
        cmp("hit_hold_lives", int'(lives), 2);
        applyStimulus(0, 1, 0, 0, 0);
        cmp("respawn_state", int'(game_state), S_PLAY);
        cmp("respawn_pulse", int'(reset_player), 1);
        cmp("respawn_freeze", int'(freeze), 0);
        applyStimulus(0, 0, 0, 0, 0);
        cmp("respawn_pulse_end", int'(reset_player), 0);

        // Lose the remaining lives to reach OVER, then restart.
        applyStimulus(0, 1, 0, 1, 0);
        cmp("second_hit_lives", int'(lives), 1);
        runTicks(HIT_FRAMES, 1'b0, 1'b0);
        applyStimulus(0, 1, 0, 1, 0);
        cmp("over_state", int'(game_state), S_OVER);
        cmp("over_lives", int'(lives), 0);
        cmp("over_freeze", int'(freeze), 1);
        runTicks(3, 1'b1, 1'b1);
        cmp("over_ignores_tick", int'(game_state), S_OVER);
        applyStimulus(0, 0, 1, 0, 0);
        cmp("restart_state", int'(game_state), S_PLAY);
        cmp("restart_lives", int'(lives), 3);
        cmp("restart_pulse", int'(reset_player), 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Finish wins over collision; clear level 0.
        applyStimulus(0, 1, 0, 1, 1);
        cmp("clear_state", int'(game_state), S_CLEAR);
        cmp("clear_lives", int'(lives), 3);
        runTicks(CLEAR_FRAMES - 1, 1'b1, 1'b1);
        cmp("clear_wait", int'(game_state), S_CLEAR);
        applyStimulus(0, 1, 0, 0, 0);
        cmp("lvl1_level", int'(current_level), 1);
        cmp("lvl1_fg", int'(foreground), 6);
        cmp("lvl1_bg", int'(background), 6);
        cmp("lvl1_speed", int'(obs_speed), 2);
        cmp("lvl1_pulse", int'(reset_player), 1);

        // Clear levels 1 and 2 to reach WIN.
        applyStimulus(0, 1, 0, 0, 1);
        runTicks(CLEAR_FRAMES, 1'b0, 1'b0);
        cmp("lvl2_fg", int'(foreground), 10);
        cmp("lvl2_speed", int'(obs_speed), 3);
        applyStimulus(0, 1, 0, 0, 1);
        runTicks(CLEAR_FRAMES, 1'b0, 1'b0);
        cmp("win_state", int'(game_state), S_WIN);
        cmp("win_level", int'(current_level), 2);
        cmp("win_pulse", int'(reset_player), 0);
        runTicks(4, 1'b0, 1'b1);
        cmp("win_hold_level", int'(current_level), 2);
        applyStimulus(0, 0, 1, 0, 0);
        cmp("win_restart_level", int'(current_level), 0);
        cmp("win_restart_state", int'(game_state), S_PLAY);

        // Reset partway through HIT; the next HIT must last the full period.
        applyStimulus(0, 1, 0, 1, 0);
        runTicks(30, 1'b0, 1'b0);
        applyStimulus(1, 1, 0, 0, 0);
        cmp("midhit_reset_state", int'(game_state), S_IDLE);
        cmp("midhit_reset_lives", int'(lives), 3);
        cmp("midhit_reset_pulse", int'(reset_player), 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        runTicks(HIT_FRAMES - 1, 1'b0, 1'b0);
        cmp("post_reset_hit_full", int'(game_state), S_HIT);
        applyStimulus(0, 1, 0, 0, 0);
        cmp("post_reset_respawn", int'(game_state), S_PLAY);

        // Random play checked against the model.
        for (int i = 0; i < 6000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/level_controller.md
# level_controller

Game-flow sequencer for the playfield renderer. Samples the per-frame `collision` and `finish_line_reached` flags from the color mapper and tracks lives and level progression. Drives the mapper's `current_level`, `foreground` and `background` inputs, the obstacle speed, and the player respawn/freeze controls of the ball/obstacle motion logic. Events are evaluated once per video frame, so the combinational hit flags are acted on exactly once per frame.

## Interface
Parameters:
- NUM_LEVELS, 3, number of levels; the last level cleared leads to WIN
- LIVES_INIT, 3, lives at game start (1..3)
- HIT_FRAMES, 60, frames of freeze after a collision before respawn
- CLEAR_FRAMES, 90, frames of freeze after reaching the finish line
- OBS_SPEED_BASE, 1, obstacle step per frame on level 0

Ports:
- Clk  in  1  system clock
- Reset  in  1  reset; one clock, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (vsync edge, detected upstream)
- start  in  1  level-sensitive start key; only its rising edge is used
- collision  in  1  player/obstacle overlap from the color mapper
- finish_line_reached  in  1  player at the finish column
- current_level  out  2  active level index
- foreground, background  out  4 each  palette indices for the color mapper
- obs_speed  out  4  obstacle step per frame
- reset_player  out  1  one-cycle pulse; motion logic returns the ball to spawn
- freeze  out  1  high means motion logic must hold all positions
- lives  out  2  remaining lives
- game_state  out  3  encoded state for the HUD

## Operation
- States (encoding): IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4, WIN=5.
- Start edge: `start_edge = start & ~start_q`. `start_q` resets to 1, so a key held through Reset does not trigger.
- IDLE: on start_edge, go to PLAY with level=0 and lives=LIVES_INIT.
- PLAY: inputs are sampled only on cycles with frame_tick=1.
  - finish_line_reached=1: go to CLEAR. It has priority over collision when both are high on the same tick.
  - else collision=1 and lives>1: decrement lives, go to HIT.
  - else collision=1 and lives==1: set lives to 0, go to OVER.
- HIT: collision and finish are ignored. Wait HIT_FRAMES ticks, then go to PLAY.
- CLEAR: wait CLEAR_FRAMES ticks. If level==NUM_LEVELS-1, go to WIN; else increment level and go to PLAY.
- OVER / WIN: on start_edge, set lives=LIVES_INIT, level=0, go to PLAY.
- Every entry into PLAY asserts reset_player for exactly one cycle.
- freeze = (state != PLAY), decoded from the registered state.
- Palette lookup: level 0 gives fg=bg=3, level 1 gives 6, level 2 gives 10. Other indices give 3.
- obs_speed = OBS_SPEED_BASE + current_level, zero-extended to 4 bits.
- Frame counter: cleared on entry to HIT/CLEAR and incremented on each frame_tick. The exit transition fires on the tick where count==N-1, so exactly N ticks elapse, the first counted tick being the one after entry.

## Timing
- Reset values: state=IDLE, current_level=0, lives=LIVES_INIT, fg=bg=3, obs_speed=OBS_SPEED_BASE, reset_player=0, freeze=1, game_state=0, counter=0.
- Latency: a triggering tick or start_edge in cycle N produces the new state, lives, level and the reset_player pulse at cycle N+1. All outputs are registered or decoded from registers.
- Reset mid-HIT/CLEAR: the counter is discarded and the block returns to IDLE the next cycle. No reset_player pulse is issued.
- frame_tick outside PLAY/HIT/CLEAR is ignored. start_edge in PLAY/HIT/CLEAR is ignored.
- lives never underflows: with lives==1, collision goes to OVER with lives=0.

## Structure
- Package `game_pkg`:
  - state enum and encodings
  - palette constants PAL_L0=3, PAL_L1=6, PAL_L2=10
  - function `level_palette(level)` returning the 4-bit index
- Sub-module `frame_timer`:
  - ports: clear, frame_tick, terminal-count value; outputs a `done` flag
  - instantiated once and shared by HIT and CLEAR

## Test plan
- Reset with start held high, then release and re-press → stays IDLE until the second edge. Then PLAY, reset_player pulse 1 cycle, lives=3, fg=bg=3, freeze=0.
- PLAY, collision on one tick → HIT, lives=2, freeze=1. After 60 ticks → PLAY plus reset_player pulse. Collision held during HIT does not decrement lives.
- Three collisions across respawns → OVER, lives=0, game_state=4. start_edge → PLAY, lives=3, level=0.
- finish and collision on the same tick → CLEAR, lives unchanged. After 90 ticks → level=1, fg=bg=6, obs_speed=2.
- Clear levels 0, 1 and 2 → WIN (game_state=5) with level held at 2 and no level increment.
- Reset asserted in HIT at count 30 → next cycle IDLE, lives=3, counter=0, no reset_player pulse.
